// File: rtl/ov5640_init_seq.sv
// Power-up configuration sequencer for the OV5640: waits out sensor power-up, verifies the
// chip ID, then streams a register LUT into an i2c_control instance with per-transaction retry.
module ov5640_init_seq #(
  parameter logic [7:0]  DEVICE_ID = 8'h78,
  parameter int          LUT_SIZE  = 252,
  parameter int          PWR_DLY   = 1_000_000,
  parameter int          CMD_DLY   = 250_000,
  parameter int          MAX_RETRY = 3,
  parameter logic [15:0] CHIP_ID   = 16'h5640
) (
  input  logic        Clk,
  input  logic        Rst_p,
  input  logic        init_start,
  output logic [7:0]  lut_index,
  input  logic [23:0] lut_data,
  output logic        wrreg_req,
  output logic        rdreg_req,
  output logic [15:0] addr,
  output logic        addr_mode,
  output logic [7:0]  wrdata,
  output logic [7:0]  device_id,
  input  logic [7:0]  rddata,
  input  logic        RW_Done,
  input  logic        ack,
  output logic        busy,
  output logic        init_done,
  output logic        init_err,
  output logic [1:0]  err_code
);

  localparam int DLY_MAX = (PWR_DLY > CMD_DLY) ? PWR_DLY : CMD_DLY;
  localparam int CNT_W   = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX + 1);
  localparam int RTY_W   = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] PWR_LAST    = CNT_W'(PWR_DLY - 1);
  localparam logic [CNT_W-1:0] CMD_LAST    = CNT_W'(CMD_DLY - 1);
  localparam logic [RTY_W-1:0] RETRY_LIMIT = RTY_W'(MAX_RETRY);
  localparam logic [7:0]       LAST_INDEX  = 8'(LUT_SIZE - 1);
  localparam logic [15:0]      DELAY_ADDR  = 16'hFFFF;
  localparam logic [15:0]      ID_H_ADDR   = 16'h300A;
  localparam logic [15:0]      ID_L_ADDR   = 16'h300B;
  localparam logic [1:0]       ERR_NACK    = 2'b01;
  localparam logic [1:0]       ERR_ID      = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PWR_WAIT,
    S_RD_ID,
    S_WAIT_ID,
    S_ID_GAP,
    S_ID_CHECK,
    S_FETCH,
    S_ISSUE,
    S_WAIT_WR,
    S_DELAY,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] dly_cnt;
  logic [RTY_W-1:0] retry_cnt;
  logic             id_sel;
  logic [7:0]       id_h, id_l;
  logic [15:0]      addr_q;
  logic [7:0]       wrdata_q;

  logic       restart, retry_inc, retry_clr, idx_clr, idx_inc, id_capture;
  logic [1:0] err_set;
  logic       lut_is_delay, retry_left, counting;

  assign lut_is_delay = (lut_data[23:8] == DELAY_ADDR);
  assign retry_left   = (retry_cnt < RETRY_LIMIT);
  assign counting     = (state == S_PWR_WAIT) || (state == S_DELAY);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    restart    = 1'b0;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    id_capture = 1'b0;
    err_set    = 2'b00;
    case (state)
      S_IDLE: begin
        if (init_start) begin
          restart    = 1'b1;
          state_next = S_PWR_WAIT;
        end
      end
      S_PWR_WAIT: if (dly_cnt == PWR_LAST) state_next = S_RD_ID;
      S_RD_ID:    state_next = S_WAIT_ID;
      S_WAIT_ID: begin
        if (RW_Done) begin
          if (ack) begin
            if (retry_left) begin
              retry_inc  = 1'b1;
              state_next = S_ID_GAP;
            end else begin
              err_set    = ERR_NACK;
              state_next = S_ERROR;
            end
          end else begin
            retry_clr  = 1'b1;
            id_capture = 1'b1;
            state_next = id_sel ? S_ID_CHECK : S_ID_GAP;
          end
        end
      end
      // Spacer so a new request never follows RW_Done back to back.
      S_ID_GAP: state_next = S_RD_ID;
      S_ID_CHECK: begin
        if ({id_h, id_l} != CHIP_ID) begin
          err_set    = ERR_ID;
          state_next = S_ERROR;
        end else begin
          idx_clr    = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_FETCH: state_next = S_ISSUE;
      S_ISSUE: state_next = lut_is_delay ? S_DELAY : S_WAIT_WR;
      S_WAIT_WR: begin
        if (RW_Done) begin
          if (!ack) begin
            retry_clr  = 1'b1;
            state_next = S_NEXT;
          end else if (retry_left) begin
            retry_inc  = 1'b1;
            state_next = S_FETCH;
          end else begin
            err_set    = ERR_NACK;
            state_next = S_ERROR;
          end
        end
      end
      S_DELAY: if (dly_cnt == CMD_LAST) state_next = S_NEXT;
      S_NEXT: begin
        if (lut_index == LAST_INDEX) begin
          state_next = S_DONE;
        end else begin
          idx_inc    = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_DONE, S_ERROR: begin
        if (init_start) begin
          restart    = 1'b1;
          state_next = S_PWR_WAIT;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Address/data are driven live in the request cycle and held from the latched copy afterwards.
  always_comb begin
    addr   = addr_q;
    wrdata = wrdata_q;
    if (state == S_ISSUE) begin
      addr   = lut_data[23:8];
      wrdata = lut_data[7:0];
    end else if (state == S_RD_ID) begin
      addr = id_sel ? ID_L_ADDR : ID_H_ADDR;
    end
  end

  assign rdreg_req = (state == S_RD_ID);
  assign wrreg_req = (state == S_ISSUE) && !lut_is_delay;
  assign addr_mode = 1'b1;
  assign device_id = DEVICE_ID;
  assign busy      = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign init_done = (state == S_DONE);
  assign init_err  = (state == S_ERROR);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst_p) begin
      state     <= S_IDLE;
      dly_cnt   <= '0;
      retry_cnt <= '0;
      lut_index <= '0;
      id_sel    <= 1'b0;
      id_h      <= '0;
      id_l      <= '0;
      err_code  <= '0;
      addr_q    <= '0;
      wrdata_q  <= '0;
    end else begin
      state <= state_next;

      // Cleared on entry so each wait state lasts exactly its parameter in cycles.
      if (!counting || (state_next != state)) dly_cnt <= '0;
      else                                    dly_cnt <= dly_cnt + CNT_W'(1);

      if (restart || retry_clr) retry_cnt <= '0;
      else if (retry_inc)       retry_cnt <= retry_cnt + RTY_W'(1);

      if (restart || idx_clr) lut_index <= '0;
      else if (idx_inc)       lut_index <= lut_index + 8'd1;

      if (restart)                  err_code <= '0;
      else if (err_set != 2'b00)    err_code <= err_set;

      if (restart) begin
        id_sel <= 1'b0;
      end else if (id_capture) begin
        if (id_sel) id_l <= rddata;
        else        id_h <= rddata;
        id_sel <= 1'b1;
      end

      if ((state == S_ISSUE) || (state == S_RD_ID)) begin
        addr_q   <= addr;
        wrdata_q <= wrdata;
      end
    end
  end

endmodule
